// File: rtl/imem_boot_loader_if.sv
// Valid/ready instruction word stream feeding the boot loader.
interface imem_boot_loader_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// Streams a program into the CPU instruction memory, optionally pads the rest
// with a fill word, and holds the CPU in reset until the image is complete.
module imem_boot_loader #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH       = 64,
  parameter int unsigned       STRIDE      = 4,
  parameter bit                PAD_EN      = 1'b1,
  parameter logic [DATA_W-1:0] PAD_WORD    = '0,
  parameter int unsigned       RELEASE_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  imem_boot_loader_if.slave          s,
  output logic                       initialize,
  output logic [DATA_W-1:0]          instruction_initialize_data,
  output logic [ADDR_W-1:0]          instruction_initialize_address,
  output logic                       instr_we,
  output logic                       cpu_rst,
  output logic                       done,
  output logic                       error,
  output logic [$clog2(DEPTH+1)-1:0] word_count,
  output logic [DATA_W-1:0]          checksum
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned REL_W = $clog2(RELEASE_CYC + 1);

  typedef enum logic [2:0] {IDLE, LOAD, PAD, RELEASE, RUN, FAULT} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [REL_W-1:0]    rel_q, rel_d;
  logic                we_q, we_d;
  logic                ready_q, ready_d;
  logic                init_q, init_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                accept;
  logic                last_slot;

  assign accept    = s.s_valid & ready_q;
  assign last_slot = (count_q == CNT_W'(DEPTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN, FAULT: if (start) state_d = LOAD;
      LOAD: begin
        if (accept) begin
          if (s.s_last)       state_d = (PAD_EN && !last_slot) ? PAD : RELEASE;
          else if (last_slot) state_d = FAULT;
        end
      end
      PAD:     if (last_slot) state_d = RELEASE;
      RELEASE: if (rel_q == REL_W'(RELEASE_CYC - 1)) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; control outputs follow the next state
  always_comb begin
    count_d    = count_q;
    checksum_d = checksum_q;
    data_d     = data_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    rel_d      = '0;
    case (state_q)
      IDLE, RUN, FAULT: begin
        if (start) begin
          count_d    = '0;
          checksum_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          we_d       = 1'b1;
          data_d     = s.s_data;
          addr_d     = ADDR_W'(count_q) * ADDR_W'(STRIDE);
          count_d    = count_q + CNT_W'(1);
          checksum_d = checksum_q + s.s_data;
        end
      end
      PAD: begin
        we_d    = 1'b1;
        data_d  = PAD_WORD;
        addr_d  = ADDR_W'(count_q) * ADDR_W'(STRIDE);
        count_d = count_q + CNT_W'(1);
      end
      RELEASE: rel_d = rel_q + REL_W'(1);
      default: ;
    endcase
    ready_d   = (state_d == LOAD);
    // Load mode stays up through the cycle carrying the final strobe.
    init_d    = (state_d == LOAD) || (state_d == PAD) || we_d;
    cpu_rst_d = (state_d != RUN);
    done_d    = (state_d == RUN);
    error_d   = (state_d == FAULT);
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      checksum_q <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      rel_q      <= '0;
      we_q       <= 1'b0;
      ready_q    <= 1'b0;
      init_q     <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      checksum_q <= checksum_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      rel_q      <= rel_d;
      we_q       <= we_d;
      ready_q    <= ready_d;
      init_q     <= init_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign s.s_ready                      = ready_q;
  assign initialize                     = init_q;
  assign instruction_initialize_data    = data_q;
  assign instruction_initialize_address = addr_q;
  assign instr_we                       = we_q;
  assign cpu_rst                        = cpu_rst_q;
  assign done                           = done_q;
  assign error                          = error_q;
  assign word_count                     = count_q;
  assign checksum                       = checksum_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: unit 0 without padding, unit 1 with
// padding, both checked against an expected-write queue and load summaries.
module tb_imem_boot_loader;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned RCYC  = 4;

  logic clk;
  logic rst;
  logic        start_a [2];
  logic        valid_a [2];
  logic        last_a  [2];
  logic [31:0] sdata_a [2];
  logic        ready_a [2];
  logic        init_a  [2];
  logic [31:0] data_a  [2];
  logic [31:0] addr_a  [2];
  logic        we_a    [2];
  logic        crst_a  [2];
  logic        done_a  [2];
  logic        err_a   [2];
  logic [4:0]  cnt_a   [2];
  logic [31:0] sum_a   [2];

  int errors = 0;
  int checks = 0;
  logic [31:0] prog [DEPTH];
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [31:0] prev_d [2];
  logic [31:0] prev_a [2];

  imem_boot_loader_if #(.DATA_W(32)) bus0 ();
  imem_boot_loader_if #(.DATA_W(32)) bus1 ();

  assign bus0.s_valid = valid_a[0];
  assign bus0.s_last  = last_a[0];
  assign bus0.s_data  = sdata_a[0];
  assign ready_a[0]   = bus0.s_ready;
  assign bus1.s_valid = valid_a[1];
  assign bus1.s_last  = last_a[1];
  assign bus1.s_data  = sdata_a[1];
  assign ready_a[1]   = bus1.s_ready;

  imem_boot_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .STRIDE(4), .PAD_EN(1'b0),
                     .PAD_WORD(32'h0), .RELEASE_CYC(RCYC)) u0 (
    .clk(clk), .rst(rst), .start(start_a[0]), .s(bus0),
    .initialize(init_a[0]), .instruction_initialize_data(data_a[0]),
    .instruction_initialize_address(addr_a[0]), .instr_we(we_a[0]),
    .cpu_rst(crst_a[0]), .done(done_a[0]), .error(err_a[0]),
    .word_count(cnt_a[0]), .checksum(sum_a[0]));

  imem_boot_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .STRIDE(4), .PAD_EN(1'b1),
                     .PAD_WORD(32'h0), .RELEASE_CYC(RCYC)) u1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .s(bus1),
    .initialize(init_a[1]), .instruction_initialize_data(data_a[1]),
    .instruction_initialize_address(addr_a[1]), .instr_we(we_a[1]),
    .cpu_rst(crst_a[1]), .done(done_a[1]), .error(err_a[1]),
    .word_count(cnt_a[1]), .checksum(sum_a[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push(input int u, input logic [63:0] v);
    if (u == 0) q0.push_back(v); else q1.push_back(v);
  endfunction

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [63:0] pop(input int u);
    if (u == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Every write strobe must match the next expected (address, data); between strobes outputs hold.
  task automatic mon(input int u);
    logic [63:0] e;
    if (we_a[u]) begin
      if (qsize(u) == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write u%0d: got addr %0h data %0h, no write expected", u, addr_a[u], data_a[u]);
      end else begin
        e = pop(u);
        chk($sformatf("wr_addr u%0d", u), 64'(addr_a[u]), 64'(e[63:32]));
        chk($sformatf("wr_data u%0d", u), 64'(data_a[u]), 64'(e[31:0]));
      end
    end else begin
      chk($sformatf("hold_data u%0d", u), 64'(data_a[u]), 64'(prev_d[u]));
      chk($sformatf("hold_addr u%0d", u), 64'(addr_a[u]), 64'(prev_a[u]));
    end
    prev_d[u] = data_a[u];
    prev_a[u] = addr_a[u];
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int u = 0; u < 2; u++) begin
        prev_d[u] = 32'h0;
        prev_a[u] = 32'h0;
      end
    end else begin
      for (int u = 0; u < 2; u++) mon(u);
    end
  end

  task automatic start_load(input int u, input int n, input bit wl);
    for (int i = 0; i < n; i++) push(u, {32'(i * 4), prog[i]});
    if (wl && u == 1)
      for (int i = n; i < DEPTH; i++) push(u, {32'(i * 4), 32'h0});
    start_a[u] = 1'b1;
    step();
    start_a[u] = 1'b0;
    chk("start_cpu_rst", 64'(crst_a[u]), 64'd1);
    chk("start_done",    64'(done_a[u]), 64'd0);
    chk("start_error",   64'(err_a[u]),  64'd0);
    chk("start_count",   64'(cnt_a[u]),  64'd0);
    chk("start_sum",     64'(sum_a[u]),  64'd0);
    chk("start_init",    64'(init_a[u]), 64'd1);
    chk("start_ready",   64'(ready_a[u]), 64'd1);
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps and stray start pulses
  task automatic stream(input int u, input int n, input bit wl, input int mode);
    int b;
    for (int i = 0; i < n; i++) begin
      if (mode == 1 && i > 0) begin
        valid_a[u] = 1'b0; sdata_a[u] = $urandom; step();
      end
      if (mode == 2) begin
        repeat ($urandom_range(0, 2)) begin
          valid_a[u] = 1'b0; sdata_a[u] = $urandom; last_a[u] = 1'($urandom); step();
        end
      end
      valid_a[u] = 1'b1;
      sdata_a[u] = prog[i];
      last_a[u]  = wl && (i == n - 1);
      if (mode == 2 && $urandom_range(0, 7) == 0) start_a[u] = 1'b1;
      b = 0;
      while (!ready_a[u] && b < 50) begin step(); b++; end
      if (b == 50) begin
        chk("ready_timeout", 64'(ready_a[u]), 64'd1);
        start_a[u] = 1'b0; valid_a[u] = 1'b0;
        return;
      end
      step();
      start_a[u] = 1'b0;
    end
    valid_a[u] = 1'b0;
    last_a[u]  = 1'b0;
  endtask

  task automatic finish(input int u, input int n, input bit wl);
    int b;
    int k;
    logic [31:0] s;
    logic [4:0] ec;
    s = 32'h0;
    for (int i = 0; i < n; i++) s = s + prog[i];
    ec = wl ? ((u == 1) ? 5'(DEPTH) : 5'(n)) : 5'(DEPTH);
    b = 0;
    while (qsize(u) != 0 && b < 60) begin step(); b++; end
    chk("writes_missing", 64'(qsize(u)), 64'd0);
    if (wl) begin
      k = 0;
      while (crst_a[u] && k < 20) begin step(); k++; end
      chk("release_cycles", 64'(k), 64'(RCYC));
      chk("run_done",  64'(done_a[u]), 64'd1);
      chk("run_init",  64'(init_a[u]), 64'd0);
      chk("run_error", 64'(err_a[u]),  64'd0);
      chk("run_ready", 64'(ready_a[u]), 64'd0);
    end else begin
      chk("fault_ready",   64'(ready_a[u]), 64'd0);
      step();
      chk("fault_error",   64'(err_a[u]),  64'd1);
      chk("fault_cpu_rst", 64'(crst_a[u]), 64'd1);
      chk("fault_done",    64'(done_a[u]), 64'd0);
      chk("fault_init",    64'(init_a[u]), 64'd0);
    end
    chk("word_count", 64'(cnt_a[u]), 64'(ec));
    chk("checksum",   64'(sum_a[u]), 64'(s));
  endtask

  task automatic do_load(input int u, input int n, input bit wl, input int mode);
    start_load(u, n, wl);
    stream(u, n, wl, mode);
    finish(u, n, wl);
  endtask

  task automatic chk_reset_vals(input int u);
    chk("rst_we",      64'(we_a[u]),    64'd0);
    chk("rst_init",    64'(init_a[u]),  64'd0);
    chk("rst_ready",   64'(ready_a[u]), 64'd0);
    chk("rst_data",    64'(data_a[u]),  64'd0);
    chk("rst_addr",    64'(addr_a[u]),  64'd0);
    chk("rst_count",   64'(cnt_a[u]),   64'd0);
    chk("rst_sum",     64'(sum_a[u]),   64'd0);
    chk("rst_cpu_rst", 64'(crst_a[u]),  64'd1);
    chk("rst_done",    64'(done_a[u]),  64'd0);
    chk("rst_error",   64'(err_a[u]),   64'd0);
  endtask

  initial begin
    int u, n, mode, b;
    bit wl;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_a[i] = 1'b0; valid_a[i] = 1'b0; last_a[i] = 1'b0; sdata_a[i] = 32'h0;
    end
    repeat (3) step();
    chk_reset_vals(0);
    chk_reset_vals(1);
    rst = 1'b1;
    step();

    prog[0] = 32'h00021020; prog[1] = 32'h00844022; prog[2] = 32'h00A63825;
    prog[3] = 32'hAC09000C; prog[4] = 32'h8C0C000C;
    do_load(0, 5, 1'b1, 0);
    chk("lit_sum5",   64'(sum_a[0]), 64'h3941887F);
    chk("lit_count5", 64'(cnt_a[0]), 64'd5);
    do_load(0, 5, 1'b1, 1);
    chk("lit_sum5_gap", 64'(sum_a[0]), 64'h3941887F);

    do_load(1, 3, 1'b1, 0);
    chk("lit_sum3",    64'(sum_a[1]), 64'h012C8867);
    chk("lit_count16", 64'(cnt_a[1]), 64'd16);
    chk("lit_last_pad_addr", 64'(addr_a[1]), 64'd60);

    for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
    do_load(0, 16, 1'b0, 2);
    do_load(0, 2, 1'b1, 0);
    do_load(0, 2, 1'b1, 0);

    repeat (10) begin
      u    = int'($urandom_range(0, 1));
      n    = int'($urandom_range(1, DEPTH));
      wl   = (n < DEPTH) ? 1'b1 : 1'($urandom);
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
      do_load(u, n, wl, mode);
    end

    // asynchronous reset in the middle of padding
    for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
    start_load(1, 3, 1'b1);
    stream(1, 3, 1'b1, 0);
    b = 0;
    while (qsize(1) > 8 && b < 40) begin step(); b++; end
    chk("pad_progress", 64'(qsize(1) <= 8), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals(1);
    q1.delete();
    step(); step();
    rst = 1'b1;
    repeat (6) begin
      step();
      chk("idle_ready",   64'(ready_a[1]), 64'd0);
      chk("idle_cpu_rst", 64'(crst_a[1]),  64'd1);
      chk("idle_done",    64'(done_a[1]),  64'd0);
    end
    do_load(1, 4, 1'b1, 2);
    do_load(0, 3, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Hardware program loader for the pipeline CPU instruction memory. It accepts a valid/ready word stream of instructions and writes them to sequential instruction addresses over the CPU's initialize / instruction_initialize_data / instruction_initialize_address interface. It optionally pads unused memory with a fill word and keeps the CPU in reset until the load is complete. It also supports re-loading a new program while the CPU is running.

Parameters:
DATA_W, 32, instruction word width
ADDR_W, 32, byte-address width driven to the CPU
DEPTH, 64, instruction memory depth in words (>=2)
STRIDE, 4, byte increment between consecutive words
PAD_EN, 1, 1 = fill words after the last one up to DEPTH with PAD_WORD
PAD_WORD, 32'h0000_0000, fill value (NOP)
RELEASE_CYC, 4, cycles cpu_rst is held after the final write (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins a (re)load
s_valid  in  1  stream word valid
s_ready  out  1  loader can accept a word
s_data  in  DATA_W  instruction word
s_last  in  1  marks the final word of the program
initialize  out  1  CPU instruction-memory load mode
instruction_initialize_data  out  DATA_W  word to write
instruction_initialize_address  out  ADDR_W  byte address of the word
instr_we  out  1  one-cycle write strobe per word
cpu_rst  out  1  active-high reset to the CPU core
done  out  1  program loaded and CPU released
error  out  1  overflow: DEPTH words accepted without s_last
word_count  out  $clog2(DEPTH+1)  number of words written, including pad words
checksum  out  DATA_W  modulo-2^DATA_W sum of accepted stream words (pad words excluded)

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE
  - s_ready=0, initialize=0, instr_we=0
  - data=0, address=0, word_count=0, checksum=0
  - cpu_rst=1, done=0, error=0
- States: IDLE, LOAD, PAD, RELEASE, RUN, FAULT.
- IDLE: s_ready=0. On start → LOAD; clear word_count, checksum and error; initialize=1 from the next cycle.
- LOAD:
  - s_ready=1 while word_count<DEPTH.
  - Accept = s_valid&s_ready. On an accept, the next cycle shows:
    - instr_we=1
    - instruction_initialize_data=s_data
    - instruction_initialize_address=word_count*STRIDE (truncated to ADDR_W)
    - word_count+1, checksum+s_data
  - Write latency is 1 cycle. Output data/address hold their last values when instr_we=0.
- Transitions out of LOAD:
  - Accept with s_last=1: if PAD_EN=1 and word_count+1<DEPTH → PAD, otherwise → RELEASE.
  - Accept at word_count=DEPTH-1 with s_last=1 is legal and goes to RELEASE.
  - Accept at word_count=DEPTH-1 with s_last=0: s_ready drops, → FAULT.
- PAD: one write per cycle (instr_we=1, data=PAD_WORD, next address). Ends after the write at address (DEPTH-1)*STRIDE, then → RELEASE. The checksum does not change.
- RELEASE: initialize=0, cpu_rst=1 for exactly RELEASE_CYC cycles, then → RUN.
- RUN: cpu_rst=0, done=1.
- Re-load: start in RUN sets cpu_rst=1 and done=0 on the next edge and enters LOAD (same entry actions as from IDLE).
- FAULT: error=1, initialize=0, cpu_rst=1, s_ready=0. Only start leaves FAULT (→ LOAD, error cleared) or reset.
- start is ignored in LOAD, PAD and RELEASE.
- s_valid is ignored in IDLE, RUN and FAULT (s_ready=0). s_data/s_last are don't-care when s_valid=0.
- Asserting reset mid-LOAD or mid-PAD aborts the load immediately and asynchronously. Partially written memory is not cleared; the CPU stays in reset.

Test Plan:
- DEPTH=16, PAD_EN=0: start, then 5 words 0x00021020,0x00844022,0x00A63825,0xAC09000C,0x8C0C000C (last on the 5th), streamed back-to-back.
  → instr_we pulses at addresses 0,4,8,12,16; word_count=5; checksum=sum mod 2^32; cpu_rst falls exactly 4 cycles after the final write; done=1.
- Same program, s_valid toggled every other cycle.
  → identical write sequence and addresses with no duplicate strobes; data holds between writes.
- DEPTH=16, PAD_EN=1, 3 words.
  → writes at 0,4,8 (data), then 12..60 with 0x00000000; word_count=16; checksum covers 3 words only.
- DEPTH=16, 16 words with s_last=0.
  → 16 writes, s_ready=0 after the 16th accept, error=1, cpu_rst=1, done=0; a further start clears error and re-loads from address 0.
- In RUN, pulse start and stream 2 words.
  → cpu_rst=1 on the next edge, writes at 0 and 4, release repeats, done=1.
- Assert rst low mid-PAD.
  → all outputs take reset values in the same cycle (asynchronous), cpu_rst=1, state IDLE; a start is required to load again.
